// File: rtl/parking_gate_ctrl.sv
// Parking lot lane controller: debounced entry/exit sensors, per-lane barrier
// FSMs with admission check and open timeout, and a serialized event arbiter.
module parking_gate_ctrl #(
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned OPEN_TIMEOUT = 1000,
  parameter int unsigned OPEN_HOUR    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_sensor,
  input  logic       entry_uni_badge,
  input  logic       exit_sensor,
  input  logic       exit_uni_badge,
  input  logic [5:0] current_hour,
  input  logic       uni_is_vacated_space,
  input  logic       is_vacated_space,
  output logic       entry_gate_open,
  output logic       exit_gate_open,
  output logic       entry_denied,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic       gate_fault
);

  typedef enum logic [2:0] {E_IDLE, E_CHECK, E_OPEN, E_DENY, E_CLOSE} ent_state_t;
  typedef enum logic [1:0] {X_IDLE, X_OPEN, X_CLOSE} ex_state_t;

  ent_state_t  ent_state_q, ent_state_d;
  ex_state_t   ex_state_q, ex_state_d;
  logic        ent_deb_q, ent_deb_d, ex_deb_q, ex_deb_d;
  logic [3:0]  ent_cnt_q, ent_cnt_d, ex_cnt_q, ex_cnt_d;
  logic        ent_uni_q, ent_uni_d, ex_uni_q, ex_uni_d;
  logic [15:0] ent_tmo_q, ent_tmo_d, ex_tmo_q, ex_tmo_d;
  logic        ent_pend_q, ent_pend_d;
  logic        ent_gate_q, ent_gate_d, ex_gate_q, ex_gate_d;
  logic        denied_q, denied_d;
  logic        entered_q, entered_d, ent_uni_out_q, ent_uni_out_d;
  logic        exited_q, exited_d, ex_uni_out_q, ex_uni_out_d;
  logic        fault_q, fault_d;
  logic        admit, ent_req, ex_req, ent_any;

  always_comb begin
    ent_deb_d     = ent_deb_q;
    ent_cnt_d     = '0;
    ex_deb_d      = ex_deb_q;
    ex_cnt_d      = '0;
    ent_state_d   = ent_state_q;
    ex_state_d    = ex_state_q;
    ent_uni_d     = ent_uni_q;
    ex_uni_d      = ex_uni_q;
    ent_tmo_d     = '0;
    ex_tmo_d      = '0;
    fault_d       = fault_q;
    ent_req       = 1'b0;
    ex_req        = 1'b0;
    entered_d     = 1'b0;
    exited_d      = 1'b0;
    ent_uni_out_d = ent_uni_out_q;
    ex_uni_out_d  = ex_uni_out_q;
    ent_pend_d    = 1'b0;

    // Flipping when the count would reach DEBOUNCE is the same edge as "counter reaches DEBOUNCE".
    if (entry_sensor != ent_deb_q) begin
      if (ent_cnt_q == 4'(DEBOUNCE - 1)) ent_deb_d = entry_sensor;
      else                               ent_cnt_d = ent_cnt_q + 4'd1;
    end
    if (exit_sensor != ex_deb_q) begin
      if (ex_cnt_q == 4'(DEBOUNCE - 1)) ex_deb_d = exit_sensor;
      else                              ex_cnt_d = ex_cnt_q + 4'd1;
    end

    admit = (current_hour >= 6'(OPEN_HOUR)) &&
            (ent_uni_q ? (uni_is_vacated_space | is_vacated_space) : is_vacated_space);

    case (ent_state_q)
      E_IDLE:  if (ent_deb_q) begin
                 ent_state_d = E_CHECK;
                 ent_uni_d   = entry_uni_badge;
               end
      E_CHECK: ent_state_d = admit ? E_OPEN : E_DENY;
      E_OPEN:  if (!ent_deb_q) begin
                 ent_state_d = E_CLOSE;
                 ent_req     = 1'b1;
               end
      E_DENY:  if (!ent_deb_q) ent_state_d = E_IDLE;
      E_CLOSE: ent_state_d = E_IDLE;
      default: ent_state_d = E_IDLE;
    endcase

    case (ex_state_q)
      X_IDLE:  if (ex_deb_q) begin
                 ex_state_d = X_OPEN;
                 ex_uni_d   = exit_uni_badge;
               end
      X_OPEN:  if (!ex_deb_q) begin
                 ex_state_d = X_CLOSE;
                 ex_req     = 1'b1;
               end
      X_CLOSE: ex_state_d = X_IDLE;
      default: ex_state_d = X_IDLE;
    endcase

    if (ent_state_q == E_OPEN) begin
      ent_tmo_d = (ent_tmo_q == '1) ? ent_tmo_q : ent_tmo_q + 16'd1;
      if (ent_tmo_d == 16'(OPEN_TIMEOUT)) fault_d = 1'b1;
    end
    if (ex_state_q == X_OPEN) begin
      ex_tmo_d = (ex_tmo_q == '1) ? ex_tmo_q : ex_tmo_q + 16'd1;
      if (ex_tmo_d == 16'(OPEN_TIMEOUT)) fault_d = 1'b1;
    end

    // Exit always wins the slot, so only the entry lane ever needs to wait.
    ent_any = ent_pend_q | ent_req;
    if (ex_req) begin
      exited_d     = 1'b1;
      ex_uni_out_d = ex_uni_q;
      ent_pend_d   = ent_any;
    end else if (ent_any) begin
      entered_d     = 1'b1;
      ent_uni_out_d = ent_uni_q;
    end

    ent_gate_d = (ent_state_d == E_OPEN);
    ex_gate_d  = (ex_state_d == X_OPEN);
    denied_d   = (ent_state_d == E_DENY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_state_q   <= E_IDLE;
      ex_state_q    <= X_IDLE;
      ent_deb_q     <= 1'b0;
      ent_cnt_q     <= '0;
      ex_deb_q      <= 1'b0;
      ex_cnt_q      <= '0;
      ent_uni_q     <= 1'b0;
      ex_uni_q      <= 1'b0;
      ent_tmo_q     <= '0;
      ex_tmo_q      <= '0;
      ent_pend_q    <= 1'b0;
      ent_gate_q    <= 1'b0;
      ex_gate_q     <= 1'b0;
      denied_q      <= 1'b0;
      entered_q     <= 1'b0;
      ent_uni_out_q <= 1'b0;
      exited_q      <= 1'b0;
      ex_uni_out_q  <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      ent_state_q   <= ent_state_d;
      ex_state_q    <= ex_state_d;
      ent_deb_q     <= ent_deb_d;
      ent_cnt_q     <= ent_cnt_d;
      ex_deb_q      <= ex_deb_d;
      ex_cnt_q      <= ex_cnt_d;
      ent_uni_q     <= ent_uni_d;
      ex_uni_q      <= ex_uni_d;
      ent_tmo_q     <= ent_tmo_d;
      ex_tmo_q      <= ex_tmo_d;
      ent_pend_q    <= ent_pend_d;
      ent_gate_q    <= ent_gate_d;
      ex_gate_q     <= ex_gate_d;
      denied_q      <= denied_d;
      entered_q     <= entered_d;
      ent_uni_out_q <= ent_uni_out_d;
      exited_q      <= exited_d;
      ex_uni_out_q  <= ex_uni_out_d;
      fault_q       <= fault_d;
    end
  end

  assign entry_gate_open    = ent_gate_q;
  assign exit_gate_open     = ex_gate_q;
  assign entry_denied       = denied_q;
  assign car_entered        = entered_q;
  assign is_uni_car_entered = ent_uni_out_q;
  assign car_exited         = exited_q;
  assign is_uni_car_exited  = ex_uni_out_q;
  assign gate_fault         = fault_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed scenarios plus random traffic, all
// outputs compared every cycle against a behavioural lane model.
module tb_parking_gate_ctrl;

  localparam int D  = 4;
  localparam int TO = 10;
  localparam int OH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       entry_sensor, entry_uni_badge, exit_sensor, exit_uni_badge;
  logic [5:0] current_hour;
  logic       uni_is_vacated_space, is_vacated_space;
  logic       entry_gate_open, exit_gate_open, entry_denied;
  logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited, gate_fault;

  int n_cmp = 0;
  int n_bad = 0;

  parking_gate_ctrl #(.DEBOUNCE(D), .OPEN_TIMEOUT(TO), .OPEN_HOUR(OH)) dut (
    .clk(clk), .rst_n(rst_n),
    .entry_sensor(entry_sensor), .entry_uni_badge(entry_uni_badge),
    .exit_sensor(exit_sensor), .exit_uni_badge(exit_uni_badge),
    .current_hour(current_hour),
    .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
    .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
    .entry_denied(entry_denied),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .gate_fault(gate_fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: each lane is a car "phase" (0 none, 1 checking,
  // 2 barrier up, 3 refused, 4 lowering); sensors filtered by run length.
  int m_deb[2], m_run[2], m_ent, m_ex, m_open[2];
  bit m_ent_uni, m_ex_uni, m_fault, m_wait_ent;
  bit o_eg, o_xg, o_den, o_ce, o_ceu, o_cx, o_cxu;

  task automatic model_reset();
    m_deb = '{0, 0}; m_run = '{0, 0}; m_open = '{0, 0};
    m_ent = 0; m_ex = 0; m_ent_uni = 0; m_ex_uni = 0; m_fault = 0; m_wait_ent = 0;
    o_eg = 0; o_xg = 0; o_den = 0; o_ce = 0; o_ceu = 0; o_cx = 0; o_cxu = 0;
  endtask

  task automatic model_step();
    int raw[2];
    int ne, nx;
    bit ent_done, ex_done, want_ent, space_ok;
    raw[0] = int'(entry_sensor); raw[1] = int'(exit_sensor);
    ne = m_ent; nx = m_ex; ent_done = 0; ex_done = 0;
    space_ok = m_ent_uni ? (uni_is_vacated_space || is_vacated_space) : is_vacated_space;
    case (m_ent)
      0: if (m_deb[0] == 1) ne = 1;
      1: ne = (int'(current_hour) >= OH && space_ok) ? 2 : 3;
      2: if (m_deb[0] == 0) begin ne = 4; ent_done = 1; end
      3: if (m_deb[0] == 0) ne = 0;
      default: ne = 0;
    endcase
    case (m_ex)
      0: if (m_deb[1] == 1) nx = 2;
      2: if (m_deb[1] == 0) begin nx = 4; ex_done = 1; end
      default: nx = 0;
    endcase
    if (m_ent == 2) begin
      if (m_open[0] < 65535) m_open[0]++;
      if (m_open[0] == TO) m_fault = 1;
    end else m_open[0] = 0;
    if (m_ex == 2) begin
      if (m_open[1] < 65535) m_open[1]++;
      if (m_open[1] == TO) m_fault = 1;
    end else m_open[1] = 0;
    want_ent = m_wait_ent || ent_done;
    o_ce = 0; o_cx = 0; m_wait_ent = 0;
    if (ex_done) begin
      o_cx = 1; o_cxu = m_ex_uni; m_wait_ent = want_ent;
    end else if (want_ent) begin
      o_ce = 1; o_ceu = m_ent_uni;
    end
    if (m_ent == 0 && ne == 1) m_ent_uni = entry_uni_badge;
    if (m_ex == 0 && nx == 2) m_ex_uni = exit_uni_badge;
    for (int l = 0; l < 2; l++) begin
      if (raw[l] != m_deb[l]) begin
        m_run[l]++;
        if (m_run[l] == D) begin m_deb[l] = raw[l]; m_run[l] = 0; end
      end else m_run[l] = 0;
    end
    m_ent = ne; m_ex = nx;
    o_eg = (ne == 2); o_xg = (nx == 2); o_den = (ne == 3);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      check_eq("outputs",
               {24'd0, entry_gate_open, exit_gate_open, entry_denied, car_entered,
                is_uni_car_entered, car_exited, is_uni_car_exited, gate_fault},
               {24'd0, o_eg, o_xg, o_den, o_ce, o_ceu, o_cx, o_cxu, m_fault});
      if (car_entered && car_exited) check_eq("evt_overlap", 1, 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int edge_n, cnt, ce_at, cx_at;
    int el, xl;
    bit ev, xv;
    rst_n = 0; entry_sensor = 1; entry_uni_badge = 0; exit_sensor = 1; exit_uni_badge = 0;
    current_hour = 6'd9; uni_is_vacated_space = 1; is_vacated_space = 1;

    // reset with sensors high, then gate must open D+2 edges after release
    tick(3);
    check_eq("rst_outs", {24'd0, entry_gate_open, exit_gate_open, entry_denied, car_entered,
             is_uni_car_entered, car_exited, is_uni_car_exited, gate_fault}, 0);
    rst_n = 1;
    edge_n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (entry_gate_open) begin edge_n = i; break; end
    end
    check_eq("rst_open_edge", edge_n, D + 2);
    tick(1); entry_sensor = 0; exit_sensor = 0;
    tick(20);

    // university car admitted via university zone only
    current_hour = 6'd9; uni_is_vacated_space = 1; is_vacated_space = 0;
    entry_uni_badge = 1; entry_sensor = 1;
    tick(20);
    check_eq("uni_gate", entry_gate_open, 1);
    entry_sensor = 0; entry_uni_badge = 0;
    edge_n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (car_entered) begin edge_n = i; break; end
    end
    check_eq("uni_evt_seen", edge_n != 0, 1);
    check_eq("uni_evt_qual", is_uni_car_entered, 1);
    @(posedge clk); #1;
    check_eq("uni_evt_width", car_entered, 0);
    tick(10);

    // denials: no general space for non-uni car, then before opening hour
    for (int k = 0; k < 2; k++) begin
      current_hour = (k == 0) ? 6'd10 : 6'd7;
      is_vacated_space = (k == 0) ? 1'b0 : 1'b1;
      uni_is_vacated_space = 1; entry_uni_badge = 0; entry_sensor = 1;
      tick(10);
      check_eq(k == 0 ? "deny_space_lamp" : "deny_hour_lamp", entry_denied, 1);
      check_eq(k == 0 ? "deny_space_gate" : "deny_hour_gate", entry_gate_open, 0);
      entry_sensor = 0;
      cnt = 0;
      repeat (15) begin @(posedge clk); #1; if (car_entered) cnt++; end
      check_eq(k == 0 ? "deny_space_evt" : "deny_hour_evt", cnt, 0);
    end

    // simultaneous completion on both lanes
    current_hour = 6'd12; is_vacated_space = 1; entry_uni_badge = 0; exit_uni_badge = 1;
    entry_sensor = 1; exit_sensor = 1;
    tick(12);
    entry_sensor = 0; exit_sensor = 0;
    ce_at = 0; cx_at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (car_exited && cx_at == 0) cx_at = i;
      if (car_entered && ce_at == 0) ce_at = i;
    end
    check_eq("simul_exit_seen", cx_at != 0, 1);
    check_eq("simul_order", ce_at - cx_at, 1);
    check_eq("simul_exit_qual", is_uni_car_exited, 1);
    tick(5);

    // glitch one cycle shorter than the debounce window
    entry_sensor = 1; exit_sensor = 1;
    tick(D - 1);
    entry_sensor = 0; exit_sensor = 0;
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (entry_gate_open || exit_gate_open || entry_denied) cnt++;
    end
    check_eq("glitch_ignored", cnt, 0);

    // timeout: fault after exactly TO cycles in OPEN, gate stays open
    tick(1); rst_n = 0; tick(2); rst_n = 1;
    entry_sensor = 1;
    edge_n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (entry_gate_open) begin edge_n = i; break; end
    end
    check_eq("tmo_gate_up", edge_n != 0, 1);
    repeat (TO - 1) begin @(posedge clk); #1; end
    check_eq("tmo_early", gate_fault, 0);
    @(posedge clk); #1;
    check_eq("tmo_fault", gate_fault, 1);
    check_eq("tmo_gate_held", entry_gate_open, 1);
    tick(1); entry_sensor = 0;
    tick(20);
    check_eq("tmo_sticky", gate_fault, 1);

    // reset while the exit barrier is up
    exit_uni_badge = 1; exit_sensor = 1;
    edge_n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (exit_gate_open) begin edge_n = i; break; end
    end
    check_eq("mid_rst_open", edge_n != 0, 1);
    tick(1);
    rst_n = 0; #1;
    check_eq("mid_rst_gate", exit_gate_open, 0);
    exit_sensor = 0;
    tick(2); rst_n = 1;
    cnt = 0;
    repeat (15) begin @(posedge clk); #1; if (car_exited) cnt++; end
    check_eq("mid_rst_no_evt", cnt, 0);

    // random traffic on both lanes
    el = 0; xl = 0; ev = 0; xv = 0;
    repeat (3000) begin
      @(negedge clk);
      if (el == 0) begin
        ev = !ev;
        el = ev ? $urandom_range(1, 30) : $urandom_range(1, 12);
        entry_sensor = ev;
        if (ev) entry_uni_badge = 1'($urandom_range(0, 1));
      end else el--;
      if (xl == 0) begin
        xv = !xv;
        xl = xv ? $urandom_range(1, 30) : $urandom_range(1, 12);
        exit_sensor = xv;
        if (xv) exit_uni_badge = 1'($urandom_range(0, 1));
      end else xl--;
      if ($urandom_range(0, 15) == 0) begin
        current_hour = 6'($urandom_range(0, 40));
        uni_is_vacated_space = 1'($urandom_range(0, 1));
        is_vacated_space = 1'($urandom_range(0, 1));
      end
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
    end
    rst_n = 1; entry_sensor = 0; exit_sensor = 0;
    tick(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
